// File: rtl/aes_core_arbiter.sv
// Round-robin arbiter sharing one iterative AES-128 encrypt core among
// NREQ requesters, with per-requester response channels and a watchdog.
module aes_core_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*128-1:0] req_plaintext,
    input  logic [NREQ*128-1:0] req_key,
    output logic [NREQ-1:0]   rsp_valid,
    input  logic [NREQ-1:0]   rsp_ready,
    output logic [127:0]      rsp_data,
    output logic              rsp_err,
    output logic              core_start,
    output logic [127:0]      core_plaintext,
    output logic [127:0]      core_key,
    input  logic [127:0]      core_ciphertext,
    input  logic              core_done,
    output logic              busy,
    output logic [IDW-1:0]    grant_id
);

    localparam int WW = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_WAIT,
        S_RESP
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]   grant_q, grant_d;
    logic [WW-1:0]    wdog_q, wdog_d;
    logic [127:0]     rsp_data_q, rsp_data_d;
    logic             rsp_err_q, rsp_err_d;
    logic [127:0]     pt_q, pt_d;
    logic [127:0]     key_q, key_d;

    logic             any_req;
    logic [IDW-1:0]   win;
    int               idx;

    // Scan from the highest offset down so the lowest offset from rr_ptr wins.
    always_comb begin
        any_req = 1'b0;
        win     = '0;
        idx     = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            if (req_valid[idx]) begin
                any_req = 1'b1;
                win     = IDW'(idx);
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        wdog_d     = wdog_q;
        rsp_data_d = rsp_data_q;
        rsp_err_d  = rsp_err_q;
        pt_d       = pt_q;
        key_d      = key_q;
        req_ready  = '0;
        rsp_valid  = '0;
        core_start = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (any_req) begin
                    req_ready[win] = 1'b1;
                    pt_d    = req_plaintext[int'(win)*128 +: 128];
                    key_d   = req_key[int'(win)*128 +: 128];
                    grant_d = win;
                    state_d = S_START;
                end
            end
            S_START: begin
                core_start = 1'b1;
                wdog_d     = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                wdog_d = wdog_q + 1'b1;
                if (core_done) begin
                    rsp_data_d = core_ciphertext;
                    rsp_err_d  = 1'b0;
                    state_d    = S_RESP;
                end else if (wdog_q == WW'(TIMEOUT - 1)) begin
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    state_d    = S_RESP;
                end
            end
            S_RESP: begin
                rsp_valid[grant_q] = 1'b1;
                if (rsp_ready[grant_q]) begin
                    rr_ptr_d = (grant_q == IDW'(NREQ - 1)) ?
                               '0 : grant_q + 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            wdog_q     <= '0;
            rsp_data_q <= '0;
            rsp_err_q  <= 1'b0;
            pt_q       <= '0;
            key_q      <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            wdog_q     <= wdog_d;
            rsp_data_q <= rsp_data_d;
            rsp_err_q  <= rsp_err_d;
            pt_q       <= pt_d;
            key_q      <= key_d;
        end
    end

    assign rsp_data       = rsp_data_q;
    assign rsp_err        = rsp_err_q;
    assign core_plaintext = pt_q;
    assign core_key       = key_q;
    assign busy           = (state_q != S_IDLE);
    assign grant_id       = grant_q;

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Directed bench for aes_core_arbiter with an 11-cycle core stub that can
// be told to hang.
module tb_aes_core_arbiter;

    localparam int NREQ = 4;
    localparam int IDW = 2;
    localparam int TIMEOUT = 16;
    localparam int LAT = 11;

    localparam logic [127:0] K0  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] P0  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    logic clk;
    logic rst;
    logic [NREQ-1:0] req_valid;
    logic [NREQ-1:0] req_ready;
    logic [NREQ*128-1:0] req_plaintext;
    logic [NREQ*128-1:0] req_key;
    logic [NREQ-1:0] rsp_valid;
    logic [NREQ-1:0] rsp_ready;
    logic [127:0] rsp_data;
    logic rsp_err;
    logic core_start;
    logic [127:0] core_plaintext;
    logic [127:0] core_key;
    logic [127:0] core_ciphertext;
    logic core_done;
    logic busy;
    logic [IDW-1:0] grant_id;

    int n_cmp;
    int n_bad;
    int cyc;
    logic hang;
    logic run;
    logic [7:0] cnt;
    logic [127:0] keys[NREQ];
    logic [127:0] pts[NREQ];

    aes_core_arbiter #(
        .NREQ(NREQ), .IDW(IDW), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_plaintext(req_plaintext),
        .req_key(req_key),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data(rsp_data),
        .rsp_err(rsp_err),
        .core_start(core_start),
        .core_plaintext(core_plaintext),
        .core_key(core_key),
        .core_ciphertext(core_ciphertext),
        .core_done(core_done),
        .busy(busy),
        .grant_id(grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in for the core: known AES vector, otherwise a keyed scramble.
    function automatic logic [127:0] model(input logic [127:0] k,
                                           input logic [127:0] p);
        if (k == K0 && p == P0) return CT0;
        return p ^ {k[63:0], k[127:64]} ^ {4{32'h5a5a_c3c3}};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            run <= 1'b0;
            cnt <= '0;
        end else if (core_start) begin
            run <= 1'b1;
            cnt <= 8'd1;
        end else if (run) begin
            cnt <= cnt + 8'd1;
            if (cnt == 8'(LAT)) run <= 1'b0;
        end
    end

    assign core_done = run && (cnt == 8'(LAT)) && !hang;
    assign core_ciphertext = model(core_key, core_plaintext);

    task automatic set_req(input int i, input logic [127:0] k,
                           input logic [127:0] p);
        req_key[i*128 +: 128] = k;
        req_plaintext[i*128 +: 128] = p;
    endtask

    task automatic wait_ready(output int id, output bit ok);
        ok = 1'b0;
        id = -1;
        for (int t = 0; t < 100; t++) begin
            #1;
            if (req_ready != '0) begin
                for (int i = 0; i < NREQ; i++)
                    if (req_ready[i]) id = i;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic wait_rsp(output int n, output bit ok);
        ok = 1'b0;
        n = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            n++;
            if (rsp_valid != '0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if ({req_ready, rsp_valid, core_start, busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 0",
                     {req_ready, rsp_valid, core_start, busy});
        end
        n_cmp++;
        if (rsp_data !== '0 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_rsp: got %h/%b want 0/0", rsp_data, rsp_err);
        end
        n_cmp++;
        if (core_key !== '0 || core_plaintext !== '0) begin
            n_bad++;
            $display("FAIL reset_core: got %h/%h want 0", core_key,
                     core_plaintext);
        end
        n_cmp++;
        if (grant_id !== '0) begin
            n_bad++;
            $display("FAIL reset_grant: got %0d want 0", grant_id);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int id;
        int n;
        bit ok;
        set_req(0, K0, P0);
        req_valid = 4'b0001;
        wait_ready(id, ok);
        n_cmp++;
        if (!ok || req_ready !== 4'b0001) begin
            n_bad++;
            $display("FAIL single_ready: got %b want 0001", req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        n_cmp++;
        if (core_start !== 1'b1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL single_start: got %b%b want 11", core_start, busy);
        end
        n_cmp++;
        if (core_key !== K0 || core_plaintext !== P0 || grant_id !== 2'd0) begin
            n_bad++;
            $display("FAIL single_latch: got %h %h %0d", core_key,
                     core_plaintext, grant_id);
        end
        wait_rsp(n, ok);
        n_cmp++;
        if (!ok || n != 12) begin
            n_bad++;
            $display("FAIL single_latency: got %0d want 12", n);
        end
        n_cmp++;
        if (rsp_valid !== 4'b0001 || rsp_data !== CT0 || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL single_rsp: got %b %h %b want 0001 %h 0",
                     rsp_valid, rsp_data, rsp_err, CT0);
        end
        rsp_ready = 4'b0001;
        @(negedge clk);
        rsp_ready = '0;
        n_cmp++;
        if (rsp_valid !== '0 || busy !== 1'b0) begin
            n_bad++;
            $display("FAIL single_done: got %b %b want 0000 0", rsp_valid, busy);
        end
    endtask

    task automatic test_round_robin();
        int id;
        int n;
        int prev;
        bit ok;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_req(i, keys[i], pts[i]);
        req_valid = '1;
        rsp_ready = '1;
        prev = 0;
        for (int g = 0; g < 5; g++) begin
            wait_ready(id, ok);
            n_cmp++;
            if (!ok || id != g % NREQ) begin
                n_bad++;
                $display("FAIL rr_grant%0d: got %0d want %0d", g, id, g % NREQ);
            end
            if (g > 0) begin
                n_cmp++;
                if (cyc - prev != 14) begin
                    n_bad++;
                    $display("FAIL rr_period%0d: got %0d want 14", g,
                             cyc - prev);
                end
            end
            prev = cyc;
            wait_rsp(n, ok);
            n_cmp++;
            if (!ok || id < 0 || rsp_valid !== 4'(1 << id) ||
                rsp_data !== model(keys[id & 3], pts[id & 3])) begin
                n_bad++;
                $display("FAIL rr_rsp%0d: got %b %h", g, rsp_valid, rsp_data);
            end
        end
        req_valid = '0;
        @(negedge clk);
        rsp_ready = '0;
    endtask

    task automatic test_backpressure();
        int id;
        int n;
        bit ok;
        bit bad;
        logic [127:0] d;
        req_valid = 4'b1010;
        wait_ready(id, ok);
        n_cmp++;
        if (!ok || id != 1) begin
            n_bad++;
            $display("FAIL bp_grant: got %0d want 1", id);
        end
        @(negedge clk);
        req_valid = 4'b1000;
        wait_rsp(n, ok);
        d = rsp_data;
        n_cmp++;
        if (!ok || rsp_valid !== 4'b0010 || d !== model(keys[1], pts[1])) begin
            n_bad++;
            $display("FAIL bp_rsp: got %b %h", rsp_valid, d);
        end
        rsp_ready = 4'b1101;
        bad = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            if (rsp_valid !== 4'b0010 || rsp_data !== d ||
                req_ready !== '0 || rsp_err !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL bp_hold: got %b %h rdy %b", rsp_valid, rsp_data,
                     req_ready);
        end
        rsp_ready = 4'b0010;
        @(negedge clk);
        #1;
        n_cmp++;
        if (rsp_valid !== '0 || req_ready !== 4'b1000) begin
            n_bad++;
            $display("FAIL bp_next: got %b %b want 0000 1000", rsp_valid,
                     req_ready);
        end
        @(negedge clk);
        req_valid = '0;
        rsp_ready = '1;
        wait_rsp(n, ok);
        n_cmp++;
        if (!ok || rsp_valid !== 4'b1000 || rsp_data !== model(keys[3], pts[3])) begin
            n_bad++;
            $display("FAIL bp_rsp3: got %b %h", rsp_valid, rsp_data);
        end
        @(negedge clk);
        rsp_ready = '0;
    endtask

    task automatic test_timeout();
        int id;
        int n;
        bit ok;
        hang = 1'b1;
        req_valid = 4'b0100;
        wait_ready(id, ok);
        @(negedge clk);
        req_valid = '0;
        n_cmp++;
        if (!ok || id != 2 || core_start !== 1'b1) begin
            n_bad++;
            $display("FAIL to_start: got id %0d start %b", id, core_start);
        end
        wait_rsp(n, ok);
        n_cmp++;
        if (!ok || n != TIMEOUT + 1) begin
            n_bad++;
            $display("FAIL to_latency: got %0d want %0d", n, TIMEOUT + 1);
        end
        n_cmp++;
        if (rsp_valid !== 4'b0100 || rsp_err !== 1'b1 || rsp_data !== '0) begin
            n_bad++;
            $display("FAIL to_rsp: got %b %b %h want 0100 1 0", rsp_valid,
                     rsp_err, rsp_data);
        end
        rsp_ready = 4'b0100;
        @(negedge clk);
        rsp_ready = '0;
        hang = 1'b0;
        req_valid = 4'b0001;
        wait_ready(id, ok);
        n_cmp++;
        if (!ok || id != 0) begin
            n_bad++;
            $display("FAIL to_next_grant: got %0d want 0", id);
        end
        @(negedge clk);
        req_valid = '0;
        wait_rsp(n, ok);
        n_cmp++;
        if (!ok || n != 12 || rsp_err !== 1'b0 ||
            rsp_data !== model(keys[0], pts[0])) begin
            n_bad++;
            $display("FAIL to_next_rsp: got n %0d %b %h", n, rsp_err, rsp_data);
        end
        rsp_ready = 4'b0001;
        @(negedge clk);
        rsp_ready = '0;
    endtask

    task automatic test_key_change();
        int id;
        int t;
        bit ok;
        bit bad;
        set_req(0, K0, P0);
        req_valid = 4'b0001;
        wait_ready(id, ok);
        @(negedge clk);
        req_valid = '0;
        set_req(0, ~K0, ~P0);
        bad = 1'b0;
        ok = 1'b0;
        for (t = 0; t < 100; t++) begin
            if (core_key !== K0 || core_plaintext !== P0) bad = 1'b1;
            @(negedge clk);
            if (rsp_valid != '0) begin
                ok = 1'b1;
                break;
            end
        end
        n_cmp++;
        if (bad || !ok) begin
            n_bad++;
            $display("FAIL kc_hold: got %h want %h", core_key, K0);
        end
        n_cmp++;
        if (rsp_valid !== 4'b0001 || rsp_data !== CT0) begin
            n_bad++;
            $display("FAIL kc_rsp: got %b %h want 0001 %h", rsp_valid,
                     rsp_data, CT0);
        end
        rsp_ready = 4'b0001;
        @(negedge clk);
        rsp_ready = '0;
    endtask

    task automatic test_reset_mid();
        int id;
        int n;
        bit ok;
        bit bad;
        set_req(1, keys[1], pts[1]);
        req_valid = 4'b0010;
        wait_ready(id, ok);
        @(negedge clk);
        req_valid = '0;
        repeat (4) @(negedge clk);
        n_cmp++;
        if (!ok || id != 1 || busy !== 1'b1) begin
            n_bad++;
            $display("FAIL rm_busy: got id %0d busy %b", id, busy);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++;
        if ({req_ready, rsp_valid, rsp_err, core_start, busy, grant_id} !== '0 ||
            rsp_data !== '0 || core_key !== '0 || core_plaintext !== '0) begin
            n_bad++;
            $display("FAIL rm_outputs: got %b %h %h",
                     {req_ready, rsp_valid, rsp_err, core_start, busy, grant_id},
                     rsp_data, core_key);
        end
        bad = 1'b0;
        repeat (15) begin
            @(negedge clk);
            if (rsp_valid !== '0 || busy !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_bad++;
            $display("FAIL rm_dropped: got rsp %b busy %b want 0", rsp_valid,
                     busy);
        end
        set_req(2, keys[2], pts[2]);
        req_valid = 4'b0100;
        wait_ready(id, ok);
        @(negedge clk);
        req_valid = '0;
        wait_rsp(n, ok);
        n_cmp++;
        if (!ok || id != 2 || grant_id !== 2'd2 || rsp_valid !== 4'b0100 ||
            rsp_data !== model(keys[2], pts[2]) || rsp_err !== 1'b0) begin
            n_bad++;
            $display("FAIL rm_req2: got %0d %b %h", grant_id, rsp_valid,
                     rsp_data);
        end
        rsp_ready = 4'b0100;
        @(negedge clk);
        rsp_ready = '0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst = 1'b1;
        hang = 1'b0;
        req_valid = '0;
        rsp_ready = '0;
        req_key = '0;
        req_plaintext = '0;
        for (int i = 0; i < NREQ; i++) begin
            keys[i] = {4{32'h0123_4567 + 32'(i) * 32'h1111_1111}};
            pts[i] = {4{32'h89ab_cdef ^ (32'(i) << 4)}};
        end
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_timeout();
        test_key_change();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
